// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the multi-channel edge detector.
//   EDGE_OFF/EDGE_RISE/EDGE_FALL/EDGE_BOTH : 2-bit per-channel mode encodings
//   edge_select()                          : maps accepted rise/fall to a tick
// -----------------------------------------------------------------------------
package edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Returns the mode-qualified tick for one channel.
  function automatic logic edge_select(input logic       rise,
                                       input logic       fall,
                                       input logic [1:0] mode);
    logic sel;
    case (mode)
      EDGE_OFF:  sel = 1'b0;
      EDGE_RISE: sel = rise;
      EDGE_FALL: sel = fall;
      EDGE_BOTH: sel = rise | fall;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
// One channel of the edge detector: synchroniser, glitch filter and
// rise/fall/tick generation. All outputs are registered.
// Ports:
//   clk          in  system clock
//   n_rst        in  asynchronous active-low reset
//   din          in  raw asynchronous input
//   mode         in  2-bit mode (off/rise/fall/both)
//   level        out filtered, synchronised level
//   tick_rising  out 1-cycle pulse on accepted 0->1
//   tick_falling out 1-cycle pulse on accepted 1->0
//   tick         out 1-cycle pulse on accepted edge matching mode
// -----------------------------------------------------------------------------
module edge_chan
  import edge_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_CNT  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       din,
  input  logic [1:0] mode,
  output logic       level,
  output logic       tick_rising,
  output logic       tick_falling,
  output logic       tick
);

  localparam int               CNT_W    = $clog2(FILTER_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   tick_rising_r;
  logic                   tick_falling_r;
  logic                   tick_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain; the oldest stage feeds the filter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Filter next-state: a new level must differ for FILTER_CNT consecutive clocks.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    rise_s      = 1'b0;
    fall_s      = 1'b0;
    if (sync_s == level_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      // Acceptance clock: level flips and the edge is reported together.
      cnt_nxt_s   = '0;
      level_nxt_s = sync_s;
      rise_s      = sync_s;
      fall_s      = ~sync_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Filter state and registered edge pulses; mode is sampled on the acceptance clock.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r          <= '0;
      level_r        <= RESET_LEVEL;
      tick_rising_r  <= 1'b0;
      tick_falling_r <= 1'b0;
      tick_r         <= 1'b0;
    end else begin
      cnt_r          <= cnt_nxt_s;
      level_r        <= level_nxt_s;
      tick_rising_r  <= rise_s;
      tick_falling_r <= fall_s;
      tick_r         <= edge_select(rise_s, fall_s, mode);
    end
  end

  assign level        = level_r;
  assign tick_rising  = tick_rising_r;
  assign tick_falling = tick_falling_r;
  assign tick         = tick_r;

endmodule

// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
// Multi-channel synchronising, debouncing edge detector with sticky pending
// flags and one aggregate interrupt.
// Ports:
//   clk          in  system clock
//   n_rst        in  asynchronous active-low reset
//   data_in      in  [WIDTH]   raw asynchronous inputs
//   mode         in  [2*WIDTH] per-channel mode, ch i = mode[2i+1:2i]
//   pend_clr     in  [WIDTH]   write-1-to-clear strobe for pending
//   irq_en       in  [WIDTH]   per-channel interrupt enable
//   level        out [WIDTH]   filtered level
//   tick_rising  out [WIDTH]   accepted 0->1 pulse
//   tick_falling out [WIDTH]   accepted 1->0 pulse
//   tick         out [WIDTH]   accepted edge matching mode
//   pending      out [WIDTH]   sticky flags set by tick
//   irq          out           registered |(pending & irq_en)
// -----------------------------------------------------------------------------
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_CNT  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   pend_clr,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   tick_rising,
  output logic [WIDTH-1:0]   tick_falling,
  output logic [WIDTH-1:0]   tick,
  output logic [WIDTH-1:0]   pending,
  output logic               irq
);

  logic [WIDTH-1:0] tick_s;
  logic [WIDTH-1:0] pending_r;
  logic             irq_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_CNT  (FILTER_CNT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk          (clk),
      .n_rst        (n_rst),
      .din          (data_in[i]),
      .mode         (mode[2*i+1:2*i]),
      .level        (level[i]),
      .tick_rising  (tick_rising[i]),
      .tick_falling (tick_falling[i]),
      .tick         (tick_s[i])
    );
  end

  // Sticky pending: a set always wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_r <= '0;
    end else begin
      pending_r <= tick_s | (pending_r & ~pend_clr);
    end
  end

  // Aggregate interrupt from the registered flags, one clock behind pending.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(pending_r & irq_en);
    end
  end

  assign tick    = tick_s;
  assign pending = pending_r;
  assign irq     = irq_r;

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int D    = SYNC + FILT - 1;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [W-1:0]   data_in;
  logic [2*W-1:0] mode;
  logic [W-1:0]   pend_clr;
  logic [W-1:0]   irq_en;
  logic [W-1:0]   level;
  logic [W-1:0]   tick_rising;
  logic [W-1:0]   tick_falling;
  logic [W-1:0]   tick;
  logic [W-1:0]   pending;
  logic           irq;

  int vecs = 0;
  int errs = 0;

  // reference model: sliding window of raw input samples per clock edge
  logic [W-1:0] hist_m [0:D-1];
  logic [W-1:0] lvl_m, rise_m, fall_m, tick_m, pend_m;
  logic         irq_m;

  edge_detect_multi #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .FILTER_CNT(FILT), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .mode(mode),
    .pend_clr(pend_clr), .irq_en(irq_en), .level(level),
    .tick_rising(tick_rising), .tick_falling(tick_falling), .tick(tick),
    .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int j = 0; j < D; j++) hist_m[j] = '0;
    lvl_m  = '0;
    rise_m = '0;
    fall_m = '0;
    tick_m = '0;
    pend_m = '0;
    irq_m  = 1'b0;
  endtask

  // one clock edge; the model accepts a new level once the last FILT synchronised
  // samples (raw samples delayed by SYNC edges) all disagree with the current level
  task automatic step();
    logic [W-1:0] lvl_n, rise_n, fall_n, tick_n, pend_n;
    logic         irq_n;
    logic         acc;
    @(posedge clk);
    irq_n  = |(pend_m & irq_en);
    pend_n = tick_m | (pend_m & ~pend_clr);
    lvl_n  = lvl_m;
    rise_n = '0;
    fall_n = '0;
    tick_n = '0;
    for (int i = 0; i < W; i++) begin
      acc = 1'b1;
      for (int j = SYNC - 1; j < D; j++)
        if (hist_m[j][i] == lvl_m[i]) acc = 1'b0;
      if (acc) begin
        lvl_n[i]  = ~lvl_m[i];
        rise_n[i] = ~lvl_m[i];
        fall_n[i] = lvl_m[i];
      end
      tick_n[i] = (rise_n[i] & mode[2*i]) | (fall_n[i] & mode[2*i+1]);
    end
    for (int j = D - 1; j > 0; j--) hist_m[j] = hist_m[j-1];
    hist_m[0] = data_in;
    lvl_m  = lvl_n;
    rise_m = rise_n;
    fall_m = fall_n;
    tick_m = tick_n;
    pend_m = pend_n;
    irq_m  = irq_n;
    #1;
  endtask

  task automatic apply_reset();
    n_rst    = 1'b0;
    data_in  = '0;
    pend_clr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    mode   = '1;
    irq_en = '1;
    apply_reset();
    vecs++;
    if (level !== 8'h00) begin errs++; $display("FAIL reset_level got=%h exp=%h", level, 8'h00); end
    for (int n = 0; n < 20; n++) begin
      step();
      vecs++;
      if ({tick, tick_rising, tick_falling} !== 24'h0) begin
        errs++; $display("FAIL reset_ticks cyc=%0d got=%h exp=0", n, {tick, tick_rising, tick_falling});
      end
      vecs++;
      if (pending !== 8'h00 || irq !== 1'b0 || level !== 8'h00) begin
        errs++; $display("FAIL reset_idle cyc=%0d pend=%h irq=%b lvl=%h exp=0", n, pending, irq, level);
      end
    end
  endtask

  task automatic test_rise();
    int first, cnt;
    mode   = 16'h0001;
    irq_en = '0;
    apply_reset();
    data_in = 8'h01;
    first = -1;
    cnt   = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (tick_rising[0]) begin cnt++; if (first < 0) first = n; end
      vecs++;
      if (tick[0] !== tick_rising[0]) begin
        errs++; $display("FAIL rise_tick_eq cyc=%0d got=%b exp=%b", n, tick[0], tick_rising[0]);
      end
    end
    vecs++;
    if (first !== 5) begin errs++; $display("FAIL rise_latency got=%0d exp=%0d", first, 5); end
    vecs++;
    if (cnt !== 1) begin errs++; $display("FAIL rise_count got=%0d exp=%0d", cnt, 1); end
    vecs++;
    if (pending[0] !== 1'b1 || level[0] !== 1'b1) begin
      errs++; $display("FAIL rise_pending got=%b/%b exp=1/1", pending[0], level[0]);
    end
  endtask

  task automatic test_glitch();
    int r, f;
    mode   = 16'h000C;
    irq_en = '0;
    apply_reset();
    r = 0;
    f = 0;
    data_in = 8'h02;
    repeat (3) begin step(); r += int'(tick_rising[1]); f += int'(tick_falling[1]); end
    data_in = 8'h00;
    for (int n = 0; n < 12; n++) begin
      step();
      r += int'(tick_rising[1]);
      f += int'(tick_falling[1]);
      vecs++;
      if (level[1] !== 1'b0) begin errs++; $display("FAIL glitch_level cyc=%0d got=%b exp=0", n, level[1]); end
    end
    vecs++;
    if (r != 0 || f != 0) begin errs++; $display("FAIL glitch_ticks got=%0d/%0d exp=0/0", r, f); end
    data_in = 8'h02;
    repeat (4) begin step(); r += int'(tick_rising[1]); f += int'(tick_falling[1]); end
    data_in = 8'h00;
    repeat (20) begin step(); r += int'(tick_rising[1]); f += int'(tick_falling[1]); end
    vecs++;
    if (r != 1 || f != 1) begin errs++; $display("FAIL pulse4_ticks got=%0d/%0d exp=1/1", r, f); end
  endtask

  task automatic test_fall_mode();
    int r, t;
    mode   = 16'h0020;
    irq_en = '0;
    apply_reset();
    r = 0;
    t = 0;
    data_in = 8'h04;
    repeat (10) begin step(); r += int'(tick_rising[2]); t += int'(tick[2]); end
    vecs++;
    if (r != 1 || t != 0 || pending[2] !== 1'b0) begin
      errs++; $display("FAIL fallmode_rise got=%0d/%0d/%b exp=1/0/0", r, t, pending[2]);
    end
    t = 0;
    data_in = 8'h00;
    repeat (10) begin step(); t += int'(tick[2]); end
    vecs++;
    if (t != 1 || pending[2] !== 1'b1) begin
      errs++; $display("FAIL fallmode_fall got=%0d/%b exp=1/1", t, pending[2]);
    end
  endtask

  task automatic test_pend_clr();
    bit seen;
    mode   = 16'h00C0;
    irq_en = 8'h08;
    apply_reset();
    data_in = 8'h08;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (tick[3]) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL pclr_timeout got=no tick exp=tick[3]"); end
    pend_clr = 8'h08;
    step();
    vecs++;
    if (pending[3] !== 1'b1 || irq !== 1'b0) begin
      errs++; $display("FAIL pclr_same_cycle got=%b/%b exp=1/0", pending[3], irq);
    end
    step();
    vecs++;
    if (pending[3] !== 1'b0 || irq !== 1'b1) begin
      errs++; $display("FAIL pclr_next got=%b/%b exp=0/1", pending[3], irq);
    end
    pend_clr = 8'h00;
    step();
    vecs++;
    if (pending[3] !== 1'b0 || irq !== 1'b0) begin
      errs++; $display("FAIL pclr_irq_drop got=%b/%b exp=0/0", pending[3], irq);
    end
  endtask

  task automatic test_reset_mid();
    int first, cnt;
    mode   = 16'h0100;
    irq_en = '0;
    apply_reset();
    data_in = 8'h10;
    repeat (4) step();
    vecs++;
    if (level[4] !== 1'b0) begin errs++; $display("FAIL rstmid_pre got=%b exp=0", level[4]); end
    n_rst = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (level !== 8'h00 || tick_rising !== 8'h00) begin
      errs++; $display("FAIL rstmid_async got=%h/%h exp=0/0", level, tick_rising);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    first = -1;
    cnt   = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (tick_rising[4]) begin cnt++; if (first < 0) first = n; end
    end
    vecs++;
    if (first !== 5 || cnt !== 1 || level[4] !== 1'b1) begin
      errs++; $display("FAIL rstmid_release got=%0d/%0d/%b exp=5/1/1", first, cnt, level[4]);
    end
  endtask

  task automatic test_random();
    mode   = 16'($urandom);
    irq_en = W'($urandom);
    apply_reset();
    data_in = W'($urandom);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) data_in[i] = ~data_in[i];
      if ($urandom_range(0, 31) == 0) mode = 16'($urandom);
      if ($urandom_range(0, 31) == 0) irq_en = W'($urandom);
      pend_clr = W'($urandom & $urandom);
      step();
      vecs++;
      if (level !== lvl_m) begin errs++; $display("FAIL rnd_level cyc=%0d got=%h exp=%h", n, level, lvl_m); end
      vecs++;
      if (tick_rising !== rise_m) begin errs++; $display("FAIL rnd_rise cyc=%0d got=%h exp=%h", n, tick_rising, rise_m); end
      vecs++;
      if (tick_falling !== fall_m) begin errs++; $display("FAIL rnd_fall cyc=%0d got=%h exp=%h", n, tick_falling, fall_m); end
      vecs++;
      if (tick !== tick_m) begin errs++; $display("FAIL rnd_tick cyc=%0d got=%h exp=%h", n, tick, tick_m); end
      vecs++;
      if (pending !== pend_m) begin errs++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", n, pending, pend_m); end
      vecs++;
      if (irq !== irq_m) begin errs++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", n, irq, irq_m); end
    end
    pend_clr = '0;
  endtask

  initial begin
    n_rst    = 1'b0;
    data_in  = '0;
    mode     = '0;
    pend_clr = '0;
    irq_en   = '0;
    model_reset();
    test_reset();
    test_rise();
    test_glitch();
    test_fall_mode();
    test_pend_clr();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
